// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit seven-segment scan driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic [1:0] {
    D0_ON = 2'd0,
    GAP0  = 2'd1,
    D1_ON = 2'd2,
    GAP1  = 2'd3
  } phase_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

  // Fixed scan order: ones, gap, tens, gap.
  function automatic phase_e next_phase(input phase_e p);
    case (p)
      D0_ON:   return GAP0;
      GAP0:    return D1_ON;
      D1_ON:   return GAP1;
      default: return D0_ON;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decimal digit to active-low segment pattern.
// Codes above 9 cannot occur upstream; they decode to a dark digit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Digit lookup.
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver fed by a 0-15 down counter.
// The displayed value is snapshotted only when a frame starts, so a digit
// never changes mid-scan.
// Optional build macro: SEG7_LEADING_BLANK_EN (dark tens digit when it is 0).
//
// state | meaning
// ------+---------------------------------------------
// D0_ON | ones digit lit (an=10) for SCAN_DIV cycles
// GAP0  | all dark for GAP_CYC cycles (anti-ghosting)
// D1_ON | tens digit lit (an=01) for SCAN_DIV cycles
// GAP1  | all dark for GAP_CYC cycles; reset state
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter logic [15:0] GAP_CYC  = 16'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  input  logic       cnt_vld,
  input  logic       hold,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp,
  output logic [3:0] disp_val
);

  phase_e      state;
  phase_e      state_nxt;
  logic [15:0] timer;
  logic [15:0] timer_nxt;
  logic        tens;
  logic [3:0]  ones;
  logic        tens_snap;
  logic [3:0]  ones_snap;
  logic        adv;
  logic        frame_start;
  logic [3:0]  dig_sel;
  logic [6:0]  dig_seg;
  logic [6:0]  seg_nxt;
  logic [1:0]  an_nxt;
  logic        dp_nxt;

  // Capture the counter value unless frozen by hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_val <= 4'd0;
    end else if (cnt_vld && !hold) begin
      disp_val <= cnt_in;
    end
  end

  // Phase advance, timer reload and the frame snapshot split (pre-edge disp_val).
  always_comb begin
    adv         = (timer == 16'd0);
    state_nxt   = adv ? next_phase(state) : state;
    frame_start = adv && (state == GAP1);
    tens_snap   = (disp_val >= 4'd10);
    ones_snap   = tens_snap ? (disp_val - 4'd10) : disp_val;
    timer_nxt   = timer - 16'd1;
    if (adv) begin
      timer_nxt = ((state_nxt == D0_ON) || (state_nxt == D1_ON)) ?
                  (SCAN_DIV - 16'd1) : (GAP_CYC - 16'd1);
    end
  end

  // Pick the digit for the phase being entered; a new frame uses the fresh snapshot.
  always_comb begin
    dig_sel = 4'd0;
    if (state_nxt == D0_ON) begin
      dig_sel = frame_start ? ones_snap : ones;
    end else if (state_nxt == D1_ON) begin
      dig_sel = {3'b000, tens};
    end
  end

  seg7_decode u_decode (
    .digit (dig_sel),
    .seg   (dig_seg)
  );

  // Output values for the phase being entered, so they register with the state.
  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = AN_OFF;
    case (state_nxt)
      D0_ON: begin
        seg_nxt = dig_seg;
        an_nxt  = AN_ONES;
      end
      D1_ON: begin
`ifdef SEG7_LEADING_BLANK_EN
        if (tens) begin
          seg_nxt = dig_seg;
          an_nxt  = AN_TENS;
        end
`else
        seg_nxt = dig_seg;
        an_nxt  = AN_TENS;
`endif
      end
      default: begin
        seg_nxt = SEG_BLANK;
        an_nxt  = AN_OFF;
      end
    endcase
    dp_nxt = !((state_nxt == D0_ON) && hold);
  end

  // Phase FSM with registered outputs; reset parks in GAP1 so the first edge starts a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= GAP1;
      timer <= 16'd0;
      tens  <= 1'b0;
      ones  <= 4'd0;
      seg   <= SEG_BLANK;
      an    <= AN_OFF;
      dp    <= 1'b1;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (frame_start) begin
        tens <= tens_snap;
        ones <= ones_snap;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with SCAN_DIV=4, GAP_CYC=2 (12-cycle frame).
// The reference model tracks position within the frame and the value
// captured at frame start, and derives digits by decimal arithmetic.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int SDI   = 4;
  localparam int GCI   = 2;
  localparam int FRAME = 2 * (SDI + GCI);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_vld = 1'b0;
  logic       hold = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;
  logic [3:0] disp_val;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  logic [6:0] enc_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         m_pos   = 11;
  int         m_val   = 0;
  int         m_frame = 0;
  int         m_tens  = 0;
  logic [6:0] exp_seg = 7'h7F;
  logic [1:0] exp_an  = 2'b11;
  logic       exp_dp  = 1'b1;
  logic [3:0] exp_val = 4'd0;

  seg7_scan_driver #(.SCAN_DIV(16'd4), .GAP_CYC(16'd2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .cnt_vld  (cnt_vld),
    .hold     (hold),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .disp_val (disp_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: frame position counter plus decimal split of the frame value.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pos = 11; m_val = 0; m_frame = 0;
      exp_seg = 7'h7F; exp_an = 2'b11; exp_dp = 1'b1; exp_val = 4'd0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) m_frame = m_val;
      if (cnt_vld && !hold) m_val = int'(cnt_in);
      exp_val = m_val[3:0];
      m_tens  = m_frame / 10;
      exp_seg = 7'h7F; exp_an = 2'b11; exp_dp = 1'b1;
      if (m_pos < SDI) begin
        exp_an  = 2'b10;
        exp_seg = enc_tab[m_frame % 10];
        exp_dp  = !hold;
      end else if (m_pos >= SDI + GCI && m_pos < 2 * SDI + GCI) begin
`ifdef SEG7_LEADING_BLANK_EN
        if (m_tens != 0) begin
          exp_an  = 2'b01;
          exp_seg = enc_tab[m_tens];
        end
`else
        exp_an  = 2'b01;
        exp_seg = enc_tab[m_tens];
`endif
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg", int'(seg), int'(exp_seg));
      chk("an", int'(an), int'(exp_an));
      chk("dp", int'(dp), int'(exp_dp));
      chk("disp_val", int'(disp_val), int'(exp_val));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_pos(input int p);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (m_pos == p) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL wait_pos: frame position %0d not reached", p);
    end
  endtask

  initial begin
    #1 rst = 1'b0;
    #3;
    chk("reset seg", int'(seg), 'h7F);
    chk("reset an", int'(an), 'h3);
    chk("reset dp", int'(dp), 1);
    chk("reset disp_val", int'(disp_val), 0);
    chk_en  = 1'b1;
    cnt_in  = 4'd0;
    cnt_vld = 1'b1;
    repeat (2) tick();
    rst = 1'b1;

    // First frame after release shows 00.
    tick();
    chk("f1 ones an", int'(an), 'h2);
    chk("f1 ones seg", int'(seg), 'h40);
    wait_pos(4);
    chk("f1 gap an", int'(an), 'h3);
    wait_pos(6);
`ifdef SEG7_LEADING_BLANK_EN
    chk("f1 tens an", int'(an), 'h3);
    chk("f1 tens seg", int'(seg), 'h7F);
`else
    chk("f1 tens an", int'(an), 'h1);
    chk("f1 tens seg", int'(seg), 'h40);
`endif

    // Sample 13 mid-frame: current frame unchanged, next frame shows 13.
    wait_pos(2);
    cnt_in = 4'd13;
    tick();
    chk("s13 disp_val", int'(disp_val), 13);
    chk("s13 no tear", int'(seg), 'h40);
    wait_pos(0);
    chk("s13 ones seg", int'(seg), 'h30);
    wait_pos(6);
    chk("s13 tens seg", int'(seg), 'h79);
    chk("s13 tens an", int'(an), 'h1);
    cnt_vld = 1'b0;

    // Down-counter sweep, one sample per frame.
    for (int v = 15; v >= 0; v--) begin
      wait_pos(5);
      cnt_in  = v[3:0];
      cnt_vld = 1'b1;
      tick();
      cnt_vld = 1'b0;
      cnt_in  = 4'(v + 7);
      wait_pos(1);
      chk("sweep ones seg", int'(seg), int'(enc_tab[v % 10]));
    end

    // Hold freezes sampling and lights dp during the ones phase.
    wait_pos(3);
    cnt_in  = 4'd9;
    cnt_vld = 1'b1;
    tick();
    chk("hold pre disp_val", int'(disp_val), 9);
    hold   = 1'b1;
    cnt_in = 4'd4;
    wait_pos(1);
    chk("hold disp_val", int'(disp_val), 9);
    chk("hold ones seg", int'(seg), 'h10);
    chk("hold dp", int'(dp), 0);
    wait_pos(4);
    chk("hold gap dp", int'(dp), 1);
    wait_pos(8);
    hold = 1'b0;
    tick();
    chk("release disp_val", int'(disp_val), 4);
    wait_pos(0);
    chk("release ones seg", int'(seg), 'h19);
    chk("release dp", int'(dp), 1);
    cnt_vld = 1'b0;

    // Sample coinciding with frame start: old value this frame, new one next.
    wait_pos(11);
    cnt_in  = 4'd10;
    cnt_vld = 1'b1;
    tick();
    cnt_vld = 1'b0;
    chk("coinc old seg", int'(seg), 'h19);
    chk("coinc disp_val", int'(disp_val), 10);
    wait_pos(0);
    chk("coinc ones seg", int'(seg), 'h40);
    wait_pos(6);
    chk("coinc tens seg", int'(seg), 'h79);
    chk("coinc tens an", int'(an), 'h1);

    // Asynchronous reset in the middle of the tens phase.
    wait_pos(7);
    rst = 1'b0;
    #1;
    chk("async seg", int'(seg), 'h7F);
    chk("async an", int'(an), 'h3);
    chk("async dp", int'(dp), 1);
    chk("async disp_val", int'(disp_val), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("post-reset an", int'(an), 'h2);
    chk("post-reset seg", int'(seg), 'h40);
    wait_pos(11);
    tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed two-digit seven-segment driver that sits directly downstream of the 4-bit binary down counter and consumes its count output. It samples the 0–15 count, splits it into decimal tens/ones, and scans two common-anode digits with a blanking gap between digits to suppress ghosting. Display values update only at frame boundaries, so a digit never tears mid-scan.

## Interface
- `SCAN_DIV`, 16'd50000 — on-time per digit, in clk cycles; ≥2
- `GAP_CYC`, 16'd8 — blanking gap after each digit, in clk cycles; ≥1
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — reset, asynchronous, active-low
- `cnt_in` input 4 — count value from the down counter (unsigned 0–15)
- `cnt_vld` input 1 — sample strobe; tie high to sample every cycle
- `hold` input 1 — freeze: blocks sampling while high
- `seg` output 7 — segments {g,f,e,d,c,b,a}, active-low, registered
- `an` output 2 — digit enables, active-low; an[0]=ones, an[1]=tens; registered
- `dp` output 1 — decimal point, active-low, registered
- `disp_val` output 4 — last sampled value, registered

## Operation
- Sampling: at a clk edge where `cnt_vld`=1 and `hold`=0, `disp_val` ← `cnt_in`; otherwise `disp_val` holds.
- Frame snapshot: on every entry to D0_ON, tens/ones registers load from `disp_val`: `tens` = (v≥10); `ones` = v≥10 ? v−10 : v (4-bit, no wrap possible).
- Phase FSM: D0_ON → GAP0 → D1_ON → GAP1 → D0_ON. A phase timer loads (len−1) on phase entry and decrements; the phase advances when the timer reads 0. Len is SCAN_DIV for the ON phases and GAP_CYC for the gaps.
- Outputs per phase:
  - D0_ON: an=2'b10, seg=enc(ones).
  - D1_ON: an=2'b01, seg=enc(tens).
  - GAP0/GAP1: an=2'b11, seg=7'h7F.
- `dp`: 0 during D0_ON when `hold`=1; 1 otherwise.
- Encoding enc(d), active-low hex: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10. Digits >9 are unreachable.
- Reset (asynchronous, any time, including mid-frame): state=GAP1, timer=0, tens=ones=0, disp_val=0, seg=7'h7F, an=2'b11, dp=1. The first edge after release enters D0_ON.
- Simultaneous `cnt_vld` sample and D0_ON entry: the snapshot takes the pre-edge `disp_val`. The new value shows from the next frame.

## Timing
- All outputs are registered and change on the same edge as the phase state.
- Frame length = 2·(SCAN_DIV+GAP_CYC) cycles.
- Worst-case latency from `cnt_in` sample to visible change = 1 cycle + one full frame.
- `hold` affects sampling on the same edge. The `dp` response appears on the next edge.

## Configuration
- `SEG7_LEADING_BLANK_EN`
  - Defined: during D1_ON with tens=0, an=2'b11 and seg=7'h7F. The tens digit is dark, and phase timing is unchanged.
  - Undefined: the tens digit shows "0" (seg=7'h40, an=2'b01).

## Structure
- Package `seg7_pkg`:
  - phase enum {D0_ON, GAP0, D1_ON, GAP1}
  - digit encoding constants SEG_0..SEG_9
  - SEG_BLANK = 7'h7F
  - AN_OFF = 2'b11
- Sub-module `seg7_decode`: combinational 4-bit digit → 7-bit active-low pattern, instantiated once per digit or once muxed by phase.

## Test plan
All scenarios use SCAN_DIV=4, GAP_CYC=2, frame = 12 cycles.
- Reset then release with cnt_in=0 held → first frame: an=10/seg=40 for 4 cycles, an=11 for 2, an=01/seg=40 for 4, an=11 for 2. With the macro defined, the tens phase instead stays an=11/seg=7F.
- cnt_vld=1, cnt_in=13 → next frame: ones phase seg=30, tens phase seg=79. disp_val=13 one cycle after the sample.
- Down-counter sweep 15→0 with cnt_vld pulsed once per frame → ones/tens sequence matches the decimal value every frame, with no value change inside a frame.
- hold=1 while cnt_in changes 9→4 → disp_val stays 9, ones seg=10, dp=0 during D0_ON. Release → 4 (seg=19) shown the following frame.
- Assert rst low mid-D1_ON → seg=7F, an=11, dp=1, disp_val=0 immediately, without waiting for a clk edge. After release, D0_ON starts on the first edge.
- cnt_in=10 sampled on the same edge as D0_ON entry → the current frame shows the old value and the next frame shows ones seg=40, tens seg=79.
